dl_skid_buf: RTL and testbench
==============================

# dl_skid_buf

Two-entry elastic pipeline register (skid buffer) with a valid/ready handshake on both sides, built on the design library's flip-flop primitives. It sits between any two pipeline stages of the core (e.g. fetch → decode), breaking the combinational ready path while sustaining one transfer per cycle. It adds one cycle of forward latency and provides a synchronous flush for branch/exception squash.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous squash of all buffered entries
- in_vld  input  1  upstream payload valid
- in_rdy  output  1  buffer can accept; registered output, no combinational input dependency
- in_data  input  WIDTH  upstream payload
- out_vld  output  1  downstream payload valid; registered
- out_rdy  input  1  downstream accepts
- out_data  output  WIDTH  downstream payload; registered
- count  output  2  occupancy, 0..2

## Operation
- Storage: main register (drives out_data) and skid register; state EMPTY (count 0), ONE (main valid), FULL (main and skid valid).
- Accept = in_vld & in_rdy. Take = out_vld & out_rdy.
- in_rdy = (state != FULL); out_vld = (state != EMPTY); both are decoded directly from state flops.
- EMPTY: accept → main ← in_data, go ONE. Otherwise stay.
- ONE: accept & take → main ← in_data, stay ONE. Accept & !take → skid ← in_data, go FULL. !accept & take → go EMPTY. Neither → stay.
- FULL: no accept possible. Take → main ← skid, go ONE. Otherwise hold.
- flush = 1: next state EMPTY regardless of in_vld/out_rdy; any accept or take in that cycle is discarded (the handshake still completes from upstream's view, but the payload is dropped). Data registers need not be cleared.
- Ordering: strict FIFO; skid content always older than any later accept.
- out_data is stable while out_vld & !out_rdy (no change until a take occurs).
- Payload registers update only on load (enable-gated); no reset is required on data, but out_data resets to 0.

## Timing
- Reset (rst_n low, asynchronous, any time incl. mid-transfer): state EMPTY, out_vld 0, in_rdy 1, count 0, out_data 0. First accept is possible in the first cycle after rst_n deasserts.
- Forward latency: payload accepted at edge N is on out_data with out_vld = 1 after edge N (visible in cycle N+1).
- Throughput: 1 transfer/cycle sustained when out_rdy is held at 1.
- Backpressure: the first cycle of out_rdy = 0 is absorbed by the skid; in_rdy falls one cycle later (registered).
- Recovery: the cycle after take in FULL, in_rdy = 1.
- Simultaneous flush and rst_n low: reset dominates (asynchronous).

## Structure
- Shared package dl_pkg: state encoding constants DL_SKID_EMPTY = 2'd0, DL_SKID_ONE = 2'd1, DL_SKID_FULL = 2'd2; state encoding equals count.
- Sub-module dl_dff_en_rn: WIDTH-parameterised enable flop with asynchronous active-low reset to 0. It is instantiated for the main and skid registers and for the state register.
- No other hierarchy; the next-state and load-enable logic lives in dl_skid_buf.

## Test plan
- Reset mid-stream: fill to FULL, assert rst_n low between edges → out_vld 0, in_rdy 1, count 0 immediately; the next accept of 0xA5 appears one cycle after rst_n release.
- Streaming: in_vld = 1 with data 1,2,3…100 and out_rdy = 1 → out_data 1..100 in order, one per cycle, in_rdy never drops, count stays 1.
- Backpressure: stream 10,11,12 and drop out_rdy for 3 cycles from the first output → count reaches 2, in_rdy = 0, out_data holds 10; on release the outputs are 10,11,12 with no loss or duplication.
- Flush while FULL and in_vld = 1 with 0x55 → next cycle count 0, out_vld 0; 0x55 never emerges.
- Random in_vld/out_rdy (10k cycles, WIDTH = 8) → scoreboard FIFO match; in_rdy never depends combinationally on out_rdy; out_data stable during stalls.

Source files
------------

// File: rtl/dl_pkg.sv
// Shared definitions for the dl_* pipeline building blocks.
// The skid-buffer state encoding doubles as its occupancy count.
package dl_pkg;

    typedef enum logic [1:0] {
        DL_SKID_EMPTY = 2'd0,
        DL_SKID_ONE   = 2'd1,
        DL_SKID_FULL  = 2'd2
    } dl_skid_state_e;

endpackage : dl_pkg

// File: rtl/dl_dff_en_rn.sv
// Enable-gated flip-flop bank with asynchronous active-low reset to zero.
module dl_dff_en_rn #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule : dl_dff_en_rn

// File: rtl/dl_skid_buf.sv
// Two-entry skid buffer: registered valid/ready on both sides, one transfer per
// cycle, one cycle of forward latency and a synchronous flush.
module dl_skid_buf
    import dl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [1:0]       state_bits_q;
    dl_skid_state_e   state_q;
    dl_skid_state_e   state_d;

    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic             main_en;
    logic [WIDTH-1:0] skid_q;
    logic             skid_en;

    logic             accept;
    logic             take;

    assign state_q  = dl_skid_state_e'(state_bits_q);

    assign in_rdy   = (state_q != DL_SKID_FULL);
    assign out_vld  = (state_q != DL_SKID_EMPTY);
    assign out_data = main_q;
    assign count    = state_bits_q;

    assign accept   = in_vld & in_rdy;
    assign take     = out_vld & out_rdy;

    always_comb begin
        state_d = state_q;
        main_d  = in_data;
        main_en = 1'b0;
        skid_en = 1'b0;

        case (state_q)
            DL_SKID_EMPTY: begin
                if (accept) begin
                    main_en = 1'b1;
                    state_d = DL_SKID_ONE;
                end
            end
            DL_SKID_ONE: begin
                if (accept && take) begin
                    main_en = 1'b1;
                end else if (accept) begin
                    skid_en = 1'b1;
                    state_d = DL_SKID_FULL;
                end else if (take) begin
                    state_d = DL_SKID_EMPTY;
                end
            end
            DL_SKID_FULL: begin
                if (take) begin
                    main_d  = skid_q;
                    main_en = 1'b1;
                    state_d = DL_SKID_ONE;
                end
            end
            default: begin
                state_d = DL_SKID_EMPTY;
            end
        endcase

        // Squash drops any same-cycle accept/take payload along with the contents.
        if (flush) begin
            state_d = DL_SKID_EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    dl_dff_en_rn #(.WIDTH(2)) u_state (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (1'b1),
        .d_i    (state_d),
        .q_o    (state_bits_q)
    );

    dl_dff_en_rn #(.WIDTH(WIDTH)) u_main (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (main_en),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    dl_dff_en_rn #(.WIDTH(WIDTH)) u_skid (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (skid_en),
        .d_i    (in_data),
        .q_o    (skid_q)
    );

endmodule : dl_skid_buf

// File: tb/tb_dl_skid_buf.sv
// Self-checking bench for dl_skid_buf: directed vector table, hand-written
// streaming/backpressure/reset sequences and a randomized scoreboard run.
module tb_dl_skid_buf;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_vld;
    logic         in_rdy;
    logic [W-1:0] in_data;
    logic         out_vld;
    logic         out_rdy;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic         flush;
        logic         in_vld;
        logic [W-1:0] in_data;
        logic         out_rdy;
        logic         exp_out_vld;
        logic         exp_in_rdy;
        logic [1:0]   exp_count;
        logic [W-1:0] exp_out_data;
    } vec_t;

    vec_t vecs[14];

    dl_skid_buf #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic f, input logic iv, input logic [W-1:0] d, input logic r);
        flush   = f;
        in_vld  = iv;
        in_data = d;
        out_rdy = r;
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic er,
                                 input logic [1:0] ec, input logic [W-1:0] ed);
        chk($sformatf("%s out_vld", tag), 32'(out_vld), 32'(ev));
        chk($sformatf("%s in_rdy", tag), 32'(in_rdy), 32'(er));
        chk($sformatf("%s count", tag), 32'(count), 32'(ec));
        chk($sformatf("%s out_data", tag), 32'(out_data), 32'(ed));
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        drive(v.flush, v.in_vld, v.in_data, v.out_rdy);
        step();
        check_outputs(tag, v.exp_out_vld, v.exp_in_rdy, v.exp_count, v.exp_out_data);
    endtask

    initial begin
        logic [W-1:0] q[$];
        logic         f, iv, r, acc, tk, rdy_a;
        logic [W-1:0] d;

        //            flush vld  data   rdy   ovld irdy cnt  odata
        vecs[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 2'd1, 8'h11};
        vecs[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 2'd2, 8'h11};
        vecs[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 2'd2, 8'h11};
        vecs[3]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 2'd1, 8'h22};
        vecs[4]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 2'd1, 8'h33};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 8'h33};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h33};
        vecs[7]  = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 2'd1, 8'h44};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd1, 8'h44};
        vecs[9]  = '{1'b1, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 2'd0, 8'h44};
        vecs[10] = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 2'd1, 8'h77};
        vecs[11] = '{1'b0, 1'b1, 8'h88, 1'b0, 1'b1, 1'b0, 2'd2, 8'h77};
        vecs[12] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 2'd0, 8'h77};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 8'h77};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        check_outputs("reset", 1'b0, 1'b1, 2'd0, 8'h00);
        rst_n = 1'b1;

        for (int unsigned i = 0; i < 14; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Streaming: one transfer per cycle, occupancy pinned at one.
        for (int unsigned i = 1; i <= 100; i++) begin
            drive(1'b0, 1'b1, W'(i), 1'b1);
            step();
            check_outputs($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, W'(i));
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        step();
        check_outputs("stream_drain", 1'b0, 1'b1, 2'd0, 8'd100);

        // Backpressure: 10 is held while the skid absorbs 11 and 12 waits.
        drive(1'b0, 1'b1, 8'd10, 1'b0);
        step();
        check_outputs("bp0", 1'b1, 1'b1, 2'd1, 8'd10);
        drive(1'b0, 1'b1, 8'd11, 1'b0);
        step();
        check_outputs("bp1", 1'b1, 1'b0, 2'd2, 8'd10);
        drive(1'b0, 1'b1, 8'd12, 1'b0);
        step();
        check_outputs("bp2", 1'b1, 1'b0, 2'd2, 8'd10);
        drive(1'b0, 1'b1, 8'd12, 1'b1);
        step();
        check_outputs("bp3", 1'b1, 1'b1, 2'd1, 8'd11);
        drive(1'b0, 1'b1, 8'd12, 1'b1);
        step();
        check_outputs("bp4", 1'b1, 1'b1, 2'd1, 8'd12);
        drive(1'b0, 1'b0, '0, 1'b1);
        step();
        check_outputs("bp5", 1'b0, 1'b1, 2'd0, 8'd12);

        // Asynchronous reset while full, then first accept straight after release.
        drive(1'b0, 1'b1, 8'h31, 1'b0);
        step();
        drive(1'b0, 1'b1, 8'h32, 1'b0);
        step();
        check_outputs("prerst", 1'b1, 1'b0, 2'd2, 8'h31);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("midrst", 1'b0, 1'b1, 2'd0, 8'h00);
        drive(1'b0, 1'b1, 8'hA5, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_outputs("postrst", 1'b1, 1'b1, 2'd1, 8'hA5);
        drive(1'b0, 1'b0, '0, 1'b1);
        step();
        check_outputs("postrst_drain", 1'b0, 1'b1, 2'd0, 8'hA5);

        // Randomized run against a queue model.
        q = {};
        for (int unsigned cyc = 0; cyc < 10000; cyc++) begin
            f  = ($urandom_range(0, 31) == 0);
            iv = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            d  = W'($urandom_range(0, 255));
            drive(f, iv, d, r);
            if (cyc % 100 == 0) begin
                #1;
                rdy_a = in_rdy;
                out_rdy = ~r;
                #1;
                chk("in_rdy_comb", 32'(in_rdy), 32'(rdy_a));
                out_rdy = r;
            end
            acc = iv && (q.size() < 2);
            tk  = r && (q.size() > 0);
            if (f) begin
                q = {};
            end else begin
                if (tk) void'(q.pop_front());
                if (acc) q.push_back(d);
            end
            step();
            chk("rnd count", 32'(count), 32'(q.size()));
            chk("rnd out_vld", 32'(out_vld), 32'(q.size() != 0));
            chk("rnd in_rdy", 32'(in_rdy), 32'(q.size() != 2));
            if (q.size() != 0) begin
                chk("rnd out_data", 32'(out_data), 32'(q[0]));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dl_skid_buf
